mult_arbiter: RTL and testbench

Shared serial 16x8 multiplier with a two-port round-robin arbiter. Filter and control blocks that need occasional coefficient multiplies submit operand pairs over valid/ready handshakes, so they need not each instantiate their own shift-add multiplier. The block grants one requester at a time, computes the fixed-point product one coefficient bit per clock and returns the result tagged with the requester id.

---
 rtl/mult_arbiter.sv | 115 +++++++++++
 tb/tb_mult_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Shared serial 16x8 shift-add multiplier with a two-port round-robin arbiter.
// One operand pair is accepted at a time; the result is tagged with the requester id.
//
// state | meaning
// IDLE  | waiting for a request; the grant is combinational
// MUL   | 8 cycles, one coefficient bit per clock, LSB first
// DONE  | result pulse cycle, then back to IDLE
module mult_arbiter #(
   parameter int FRAC = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [15:0] req0_a,
   input  logic [7:0]  req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [15:0] req1_a,
   input  logic [7:0]  req1_b,
   output logic        res_valid,
   output logic        res_id,
   output logic [15:0] res_y,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t      state;
   logic        last_grant;
   logic        grant_any;
   logic        grant_id;
   logic        id_lat;
   logic [15:0] a_lat;
   logic [7:0]  b_lat;
   logic [23:0] acc;
   logic [23:0] acc_next;
   logic [2:0]  cnt;

   // On a tie the port that did not win last time is served.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = 1'b0;
      if (state == IDLE) begin
         if (req0_valid && req1_valid) begin
            grant_any = 1'b1;
            grant_id  = ~last_grant;
         end else if (req0_valid) begin
            grant_any = 1'b1;
            grant_id  = 1'b0;
         end else if (req1_valid) begin
            grant_any = 1'b1;
            grant_id  = 1'b1;
         end
      end
   end

   assign req0_ready = grant_any && !grant_id;
   assign req1_ready = grant_any &&  grant_id;

   always_comb begin
      acc_next = acc;
      if (b_lat[cnt])
         acc_next = acc + ({8'd0, a_lat} << cnt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         id_lat     <= 1'b0;
         a_lat      <= '0;
         b_lat      <= '0;
         acc        <= '0;
         cnt        <= '0;
         res_valid  <= 1'b0;
         res_id     <= 1'b0;
         res_y      <= '0;
         busy       <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_any) begin
                  a_lat      <= grant_id ? req1_a : req0_a;
                  b_lat      <= grant_id ? req1_b : req0_b;
                  id_lat     <= grant_id;
                  last_grant <= grant_id;
                  acc        <= '0;
                  cnt        <= '0;
                  busy       <= 1'b1;
                  state      <= MUL;
               end
            end
            MUL: begin
               acc <= acc_next;
               cnt <= cnt + 3'd1;
               // Result registers load on the last bit so they are valid during DONE.
               if (cnt == 3'd7) begin
                  res_valid <= 1'b1;
                  res_y     <= acc_next[FRAC+15:FRAC];
                  res_id    <= id_lat;
                  state     <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: FRAC=8 and FRAC=0 instances share stimulus
// and are compared against hand-computed products.
module tb_mult_arbiter;

   logic        clk;
   logic        rst_n;
   logic        v0, v1;
   logic [15:0] a0, a1;
   logic [7:0]  b0, b1;

   logic        r0, r1, rv, rid, bsy;
   logic [15:0] ry;
   logic        r0_z, r1_z, rv_z, rid_z, bsy_z;
   logic [15:0] ry_z;

   int n_chk  = 0;
   int n_fail = 0;

   mult_arbiter #(.FRAC(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0),
      .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1),
      .res_valid(rv), .res_id(rid), .res_y(ry), .busy(bsy)
   );

   mult_arbiter #(.FRAC(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_ready(r0_z), .req0_a(a0), .req0_b(b0),
      .req1_valid(v1), .req1_ready(r1_z), .req1_a(a1), .req1_b(b1),
      .res_valid(rv_z), .res_id(rid_z), .res_y(ry_z), .busy(bsy_z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        port;
      logic [15:0] a;
      logic [7:0]  b;
      logic [15:0] y8;
      logic [15:0] y0;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic port, input logic v, input logic [15:0] a, input logic [7:0] b);
      if (port) begin v1 = v; a1 = a; b1 = b; end
      else      begin v0 = v; a0 = a; b0 = b; end
   endtask

   // One complete transaction on one port; operands are scrambled right after
   // the handshake and valid is held through MUL to show ready stays low.
   task automatic run_txn(input logic port, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] e8, input logic [15:0] e0, input string nm);
      int waited = 0;
      @(negedge clk);
      drive(port, 1'b1, a, b);
      #1;
      while (!(port ? r1 : r0) && waited < 30) begin
         @(negedge clk); #1;
         waited++;
      end
      if (waited >= 30) begin
         chk({nm, "_grant_timeout"}, 1, 0);
         drive(port, 1'b0, a, b);
         return;
      end
      chk({nm, "_other_ready"}, port ? r0 : r1, 0);
      @(posedge clk); #1;
      drive(port, 1'b1, ~a, ~b);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k <= 9) begin
            chk({nm, "_ready_busy"}, {r0, r1}, 2'b00);
            chk({nm, "_busy"}, bsy, 1);
            chk({nm, "_res_valid"}, rv, (k == 9) ? 1 : 0);
         end else begin
            chk({nm, "_busy_end"}, bsy, 0);
            chk({nm, "_res_valid_end"}, rv, 0);
         end
         if (k == 9) begin
            chk({nm, "_res_y8"}, ry, e8);
            chk({nm, "_res_y0"}, ry_z, e0);
            chk({nm, "_res_id"}, rid, port);
            chk({nm, "_res_valid_f0"}, rv_z, 1);
            drive(port, 1'b0, a, b);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int res_n, hs_n, last_hs;
      logic seen;

      vecs[0] = '{1'b0, 16'h8000, 8'h80, 16'h4000, 16'h0000};
      vecs[1] = '{1'b1, 16'hFFFF, 8'hFF, 16'hFEFF, 16'hFF01};
      vecs[2] = '{1'b1, 16'h1234, 8'h00, 16'h0000, 16'h0000};
      vecs[3] = '{1'b0, 16'h1234, 8'h02, 16'h0024, 16'h2468};
      vecs[4] = '{1'b0, 16'h0001, 8'h01, 16'h0000, 16'h0001};
      vecs[5] = '{1'b1, 16'h00FF, 8'h10, 16'h000F, 16'h0FF0};
      vecs[6] = '{1'b0, 16'hABCD, 8'h5A, 16'h3C66, 16'h6612};
      vecs[7] = '{1'b1, 16'h0100, 8'hFF, 16'h00FF, 16'hFF00};

      rst_n = 1'b1;
      v0 = 0; v1 = 0; a0 = 0; a1 = 0; b0 = 0; b1 = 0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_res_valid", rv, 0);
      chk("rst_res_y", ry, 0);
      chk("rst_res_id", rid, 0);
      chk("rst_busy", bsy, 0);
      chk("rst_ready", {r0, r1}, 2'b00);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++)
         run_txn(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].y8, vecs[i].y0, $sformatf("vec%0d", i));

      // Continuous contention after reset: 0 wins first, then strict alternation.
      do_reset();
      @(negedge clk);
      v0 = 1; a0 = 16'h1000; b0 = 8'h30;
      v1 = 1; a1 = 16'h0200; b1 = 8'h07;
      res_n = 0; hs_n = 0; last_hs = 0;
      for (int cyc = 0; cyc < 80 && res_n < 4; cyc++) begin
         #1;
         chk("cont_one_ready", r0 & r1, 0);
         if (r0 || r1) begin
            chk("cont_rr_order", r1, hs_n % 2);
            if (hs_n > 0) chk("cont_hs_spacing", cyc - last_hs, 10);
            last_hs = cyc;
            hs_n++;
         end
         if (rv) begin
            chk("cont_res_id", rid, res_n % 2);
            chk("cont_res_y8", ry, rid ? 16'h000E : 16'h0300);
            chk("cont_res_y0", ry_z, rid ? 16'h0E00 : 16'h0000);
            res_n++;
         end
         @(negedge clk);
      end
      v0 = 0; v1 = 0;
      chk("cont_results", res_n, 4);

      // Requester 1 raises and drops valid while busy: nothing is committed.
      repeat (2) @(negedge clk);
      v0 = 1; a0 = 16'h0003; b0 = 8'h03;
      #1 chk("drop_p0_ready", r0, 1);
      @(posedge clk); #1 v0 = 0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (k == 3) begin v1 = 1; a1 = 16'h7777; b1 = 8'h77; end
         if (k == 4) chk("drop_p1_ready_busy", r1, 0);
         if (k == 6) v1 = 0;
         if (k == 9) begin
            chk("drop_res_valid", rv, 1);
            chk("drop_res_id", rid, 0);
            chk("drop_res_y0", ry_z, 16'h0009);
         end
      end
      seen = 0;
      repeat (15) begin
         @(negedge clk);
         seen = seen | bsy | rv;
      end
      chk("drop_no_txn", seen, 0);

      // Reset in the 4th MUL cycle aborts the transaction.
      run_txn(1'b1, 16'hFFFF, 8'hFF, 16'hFEFF, 16'hFF01, "pre_abort");
      @(negedge clk);
      v0 = 1; a0 = 16'h4321; b0 = 8'h77;
      #1 chk("abort_ready", r0, 1);
      @(posedge clk); #1 v0 = 0;
      repeat (4) @(negedge clk);
      chk("abort_busy_before", bsy, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_res_valid", rv, 0);
      chk("abort_res_y", ry, 0);
      chk("abort_res_id", rid, 0);
      chk("abort_busy", bsy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         seen = seen | rv | bsy;
      end
      chk("abort_no_result", seen, 0);

      v0 = 1; a0 = 16'h1234; b0 = 8'h02;
      v1 = 1; a1 = 16'h5555; b1 = 8'h55;
      #1;
      chk("tie_after_reset_r0", r0, 1);
      chk("tie_after_reset_r1", r1, 0);
      v0 = 0; v1 = 0;
      run_txn(1'b0, 16'h1234, 8'h02, 16'h0024, 16'h2468, "post_abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1);
   end

endmodule
